// File: rtl/belt_pkg.sv
// Shared belt definitions: default operand width, belt depth and belt index type.
package belt_pkg;

    localparam int unsigned DEFAULT_BIT_WIDTH  = 47;
    localparam int unsigned DEFAULT_BELT_DEPTH = 16;

    typedef logic [$clog2(DEFAULT_BELT_DEPTH)-1:0] belt_index_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    always_comb begin
        int unsigned j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            j = (32'(last_grant) + k) % NUM_REQ;
            if (!any_grant && req[IDX_W'(j)]) begin
                any_grant           = 1'b1;
                grant[IDX_W'(j)]    = 1'b1;
                grant_idx           = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/belt_drop_arbiter.sv
// Arbitrates NUM_REQ result producers onto a single belt write port, one push per cycle.
module belt_drop_arbiter
    import belt_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = DEFAULT_BIT_WIDTH,
    parameter int unsigned BELT_DEPTH = DEFAULT_BELT_DEPTH,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          sync_rst,
    input  logic                          clk_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          hold,
    output logic                          push,
    output logic [BIT_WIDTH-1:0]          push_data,
    output logic [$clog2(NUM_REQ)-1:0]    push_src,
    output logic [$clog2(BELT_DEPTH)-1:0] drop_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BELT_DEPTH);

    logic [IDX_W-1:0]     last_grant;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 any_grant;
    logic                 grant_en;
    logic                 transfer;
    logic                 push_q;
    logic [BIT_WIDTH-1:0] sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    assign grant_en  = clk_en & ~hold & ~sync_rst;
    assign req_ready = (grant_en && any_grant) ? grant : '0;
    assign transfer  = |(req_valid & req_ready);

    // Reset also masks a registered push so a pending write never reaches the belt.
    assign push = push_q & clk_en & ~sync_rst;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            push_q     <= 1'b0;
            push_data  <= '0;
            push_src   <= '0;
            drop_count <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (clk_en) begin
            push_q <= transfer;
            if (transfer) begin
                push_data  <= sel_data;
                push_src   <= grant_idx;
                last_grant <= grant_idx;
            end
            if (push_q) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_belt_drop_arbiter.sv
// Bench for belt_drop_arbiter: directed scenarios plus randomized producers against a reference model.
module tb_belt_drop_arbiter;
    import belt_pkg::*;

    localparam int N  = 4;
    localparam int BW = 47;
    localparam int D  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            hold;
    logic [N-1:0]    valid;
    logic [N*BW-1:0] data;
    logic [N-1:0]    req_ready;
    logic            push;
    logic [BW-1:0]   push_data;
    logic [1:0]      push_src;
    belt_index_t     drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_lg;
    bit          m_pq;
    logic [BW-1:0] m_pd;
    int          m_ps;
    int          m_cnt;
    int          last_xfer;
    int          src_log[$];

    belt_drop_arbiter #(
        .BIT_WIDTH  (BW),
        .BELT_DEPTH (D),
        .NUM_REQ    (N)
    ) dut (
        .clk        (clk),
        .sync_rst   (rst),
        .clk_en     (en),
        .req_valid  (valid),
        .req_data   (data),
        .req_ready  (req_ready),
        .hold       (hold),
        .push       (push),
        .push_data  (push_data),
        .push_src   (push_src),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs before the edge, then advance the model across it.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_ready;
        bit exp_push;
        #3;
        g = -1;
        if (en && !hold && !rst) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_lg + k) % N;
                if (g < 0 && valid[j]) g = j;
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        exp_push  = m_pq && en && !rst;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("push", 64'(push), 64'(exp_push));
        check("push_data", 64'(push_data), 64'(m_pd));
        check("push_src", 64'(push_src), 64'(m_ps));
        check("drop_count", 64'(drop_count), 64'(m_cnt));
        if (push === 1'b1) src_log.push_back(int'(push_src));
        @(posedge clk);
        #1;
        if (rst) begin
            m_pq = 0; m_pd = '0; m_ps = 0; m_cnt = 0; m_lg = N - 1;
        end else if (en) begin
            if (exp_push) m_cnt = (m_cnt + 1) % D;
            m_pq = (g >= 0);
            if (g >= 0) begin
                m_pd = data[g*BW +: BW];
                m_ps = g;
                m_lg = g;
            end
        end
        last_xfer = g;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [BW-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; hold = 1'b0; valid = '0; data = '0;
        @(posedge clk); @(posedge clk); #1;
        m_pq = 0; m_pd = '0; m_ps = 0; m_cnt = 0; m_lg = N - 1; last_xfer = -1;
        check("rst_push", 64'(push), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_push_data", 64'(push_data), 64'(0));
        check("rst_push_src", 64'(push_src), 64'(0));
        check("rst_drop_count", 64'(drop_count), 64'(0));
        rst = 1'b0;

        // All four producers pending: 0,1,2,3,0,1,2,3
        for (int i = 0; i < N; i++) data[i*BW +: BW] = BW'(64'h100 + i);
        valid = 4'b1111;
        src_log.delete();
        cycles(8);
        valid = '0;
        cycle();
        check("rr_push_count", 64'(src_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) check("rr_src_seq", 64'(src_log[i]), 64'(i % N));
        check("rr_drop_count", 64'(drop_count), 64'(8));

        // Single producer every cycle
        data[2*BW +: BW] = 47'h1234;
        valid = 4'b0100;
        cycles(6);
        valid = '0;
        cycle();

        // 17 pushes from reset wrap the counter to 1
        rst = 1'b1; cycle(); rst = 1'b0;
        valid = 4'b1111;
        cycles(17);
        valid = '0;
        cycle();
        check("wrap_drop_count", 64'(drop_count), 64'(1));

        // Transfer then clock disabled for 3 cycles
        src_log.delete();
        valid = 4'b0010; data[1*BW +: BW] = 47'h5a5a;
        cycle();
        valid = '0; en = 1'b0;
        cycles(3);
        en = 1'b1;
        cycles(2);
        check("clken_push_count", 64'(src_log.size()), 64'(1));
        check("clken_push_src", 64'(src_log[0]), 64'(1));

        // Hold blocks grants; release grants 1 then 3
        rst = 1'b1; cycle(); rst = 1'b0;
        src_log.delete();
        hold = 1'b1; valid = 4'b1010;
        data[1*BW +: BW] = 47'h111; data[3*BW +: BW] = 47'h333;
        cycles(3);
        hold = 1'b0;
        cycle();
        valid = 4'b1000;
        cycle();
        valid = '0;
        cycles(2);
        check("hold_push_count", 64'(src_log.size()), 64'(2));
        check("hold_first", 64'(src_log[0]), 64'(1));
        check("hold_second", 64'(src_log[1]), 64'(3));

        // Reset right after a transfer discards the pending push
        src_log.delete();
        valid = 4'b0100;
        cycle();
        rst = 1'b1; valid = 4'b1010;
        cycle();
        rst = 1'b0;
        check("rstmid_drop_count", 64'(drop_count), 64'(0));
        check("rstmid_no_push", 64'(src_log.size()), 64'(0));
        cycle();
        valid = '0;
        cycle();
        check("rstmid_next_src", 64'(src_log.size() > 0 ? src_log[0] : -1), 64'(1));

        // Randomized producers honouring valid/data stability until accepted
        last_xfer = -1;
        for (int c = 0; c < 300; c++) begin
            if (last_xfer >= 0) begin
                valid[last_xfer] = 1'($urandom_range(0, 1));
                data[last_xfer*BW +: BW] = rnd_word();
            end
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && $urandom_range(0, 2) == 0) begin
                    valid[i] = 1'b1;
                    data[i*BW +: BW] = rnd_word();
                end
            end
            en   = ($urandom_range(0, 7) != 0);
            hold = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 60) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
